// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier.
// The requester drives the operand side and consumes the result side.
interface mul8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// Unsigned 8x8 -> 16-bit multiplier built by time-sharing one combinational
// 4x4 array multiplier over four nibble passes with shift-and-accumulate.
// Optional register stage (PIPE_MUL=1) after the 4x4 product.

// Combinational 4x4 array multiplier: sum of AND-gated, shifted rows.
module multiplier4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  // Accumulate one partial-product row per multiplier bit.
  always_comb begin
    // NOTE: always_comb uses blocking '=' so each row sees the running sum;
    // assigning o_p first also guarantees no latch is inferred.
    o_p = '0;
    for (int i = 0; i < 4; i++) begin
      o_p = o_p + ({4'b0000, (i_a & {4{i_b[i]}})} << i);
    end
  end
endmodule

module mul8_seq_ctrl #(
  parameter int PIPE_MUL = 0
) (
  input  logic            clk,
  input  logic            rst,
  mul8_seq_ctrl_if.slave  bus
);

  localparam bit PIPE = (PIPE_MUL != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_step;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic [15:0] r_p;
  logic [7:0]  r_partial;
  logic        r_out_valid;
  logic        r_in_ready;
  logic        r_busy;

  logic [3:0]  w_a_nib;
  logic [3:0]  w_b_nib;
  logic [7:0]  w_prod;
  logic [7:0]  w_pass;
  logic [15:0] w_addend;
  logic [15:0] w_sum;
  logic        w_last;

  // Step bit 0 picks the multiplicand nibble, step bit 1 the multiplier
  // nibble, giving the pass order lo*lo, hi*lo, lo*hi, hi*hi.
  assign w_a_nib = r_step[0] ? r_a[7:4] : r_a[3:0];
  assign w_b_nib = r_step[1] ? r_b[7:4] : r_b[3:0];

  multiplier4bit u_mul4 (
    .i_a (w_a_nib),
    .i_b (w_b_nib),
    .o_p (w_prod)
  );

  // With the pipeline stage the add consumes the registered partial, which
  // was produced with the same r_step still in place.
  assign w_pass = PIPE ? r_partial : w_prod;
  assign w_last = (r_step == 2'd3);
  assign w_sum  = r_acc + w_addend;

  // Align the zero-extended partial product to its nibble weight.
  always_comb begin
    w_addend = 16'h0000;
    case (r_step)
      2'd0:    w_addend = {8'h00, w_pass};
      2'd1,
      2'd2:    w_addend = {4'h0, w_pass, 4'h0};
      default: w_addend = {w_pass, 8'h00};
    endcase
  end

  // Control FSM with step counter, operand latches, accumulator and
  // registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= IDLE;
      r_step      <= 2'd0;
      r_a         <= 8'h00;
      r_b         <= 8'h00;
      r_acc       <= 16'h0000;
      r_p         <= 16'h0000;
      r_partial   <= 8'h00;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_acc      <= 16'h0000;
            r_step     <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= CALC;
          end
        end

        CALC, WAIT: begin
          if (PIPE && (r_state == CALC)) begin
            r_partial <= w_prod;
            r_state   <= WAIT;
          end else if (w_last) begin
            r_acc       <= w_sum;
            r_p         <= w_sum;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_acc   <= w_sum;
            r_step  <= r_step + 2'd1;
            r_state <= CALC;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.p         = r_p;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl: one instance per PIPE_MUL setting,
// table-driven product vectors plus latency, backpressure, abort and
// operand-stability sequences, and random back-to-back traffic.
module tb_mul8_seq_ctrl;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       in_valid;
  logic [1:0]       out_ready;
  logic [1:0][7:0]  a;
  logic [1:0][7:0]  b;

  logic [1:0]       in_ready_w;
  logic [1:0]       out_valid_w;
  logic [1:0]       busy_w;
  logic [1:0][15:0] p_w;

  int n_checks = 0;
  int n_fail   = 0;

  mul8_seq_ctrl_if bus0 ();
  mul8_seq_ctrl_if bus1 ();

  assign bus0.in_valid  = in_valid[0];
  assign bus0.a         = a[0];
  assign bus0.b         = b[0];
  assign bus0.out_ready = out_ready[0];
  assign bus1.in_valid  = in_valid[1];
  assign bus1.a         = a[1];
  assign bus1.b         = b[1];
  assign bus1.out_ready = out_ready[1];

  assign in_ready_w  = {bus1.in_ready,  bus0.in_ready};
  assign out_valid_w = {bus1.out_valid, bus0.out_valid};
  assign busy_w      = {bus1.busy,      bus0.busy};
  assign p_w[0]      = bus0.p;
  assign p_w[1]      = bus1.p;

  mul8_seq_ctrl #(.PIPE_MUL(0)) u_dut0 (.clk(clk), .rst(rst[0]), .bus(bus0));
  mul8_seq_ctrl #(.PIPE_MUL(1)) u_dut1 (.clk(clk), .rst(rst[1]), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request/response transaction on instance sel, with optional result
  // backpressure and operand scrambling while the product is in flight.
  task automatic run_mul(input int sel, input logic [7:0] va, input logic [7:0] vb,
                         input logic [15:0] vp, input int bp, input bit scramble,
                         input string tag);
    int          guard;
    int          lat;
    int          exp_lat;
    bit          ok;
    logic [15:0] held;
    exp_lat = (sel == 1) ? 8 : 4;
    guard = 0;
    while (in_ready_w[sel] !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready_w[sel]), 32'd1);
    in_valid[sel] = 1'b1;
    a[sel] = va;
    b[sel] = vb;
    tick();
    in_valid[sel] = 1'b0;
    lat = 0;
    ok  = 1'b1;
    while (out_valid_w[sel] !== 1'b1 && lat < 20) begin
      if (in_ready_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) ok = 1'b0;
      if (scramble) begin
        a[sel] = 8'($urandom);
        b[sel] = 8'($urandom);
        in_valid[sel] = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    in_valid[sel] = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " product"}, 32'(p_w[sel]), 32'(vp));
    check({tag, " in_ready=0 busy=1 while computing"}, 32'(ok), 32'd1);
    held = p_w[sel];
    ok = 1'b1;
    for (int i = 0; i < bp; i++) begin
      in_valid[sel] = 1'b1;
      a[sel] = ~va;
      b[sel] = ~vb;
      tick();
      if (out_valid_w[sel] !== 1'b1 || p_w[sel] !== held ||
          in_ready_w[sel] !== 1'b0 || busy_w[sel] !== 1'b1) ok = 1'b0;
    end
    in_valid[sel] = 1'b0;
    if (bp > 0) check({tag, " hold under backpressure"}, 32'(ok), 32'd1);
    out_ready[sel] = 1'b1;
    tick();
    out_ready[sel] = 1'b0;
    check({tag, " {out_valid,in_ready,busy} after handshake"},
          32'({out_valid_w[sel], in_ready_w[sel], busy_w[sel]}), 32'b010);
    check({tag, " p kept after handshake"}, 32'(p_w[sel]), 32'(vp));
  endtask

  // Abort a 0xFF*0xFF request on its second compute cycle, then prove the
  // instance is clean and still computes correctly.
  task automatic reset_mid(input int sel);
    bit seen;
    in_valid[sel] = 1'b1;
    a[sel] = 8'hFF;
    b[sel] = 8'hFF;
    tick();
    in_valid[sel] = 1'b0;
    tick();
    rst[sel] = 1'b1;
    tick();
    rst[sel] = 1'b0;
    check($sformatf("abort%0d {out_valid,p,busy,in_ready}", sel),
          32'({out_valid_w[sel], p_w[sel], busy_w[sel], in_ready_w[sel]}),
          32'({1'b0, 16'h0000, 1'b0, 1'b1}));
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid_w[sel] !== 1'b0) seen = 1'b1;
    end
    check($sformatf("abort%0d no stale out_valid", sel), 32'(seen), 32'd0);
    run_mul(sel, 8'h03, 8'h05, 16'h000F, 0, 1'b0, $sformatf("abort%0d follow-up", sel));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{a: 8'h12, b: 8'h34, p: 16'h03A8};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
    vecs[2] = '{a: 8'h00, b: 8'hB7, p: 16'h0000};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, p: 16'h3A02};
    vecs[4] = '{a: 8'h01, b: 8'h80, p: 16'h0080};
    vecs[5] = '{a: 8'h03, b: 8'h05, p: 16'h000F};
    vecs[6] = '{a: 8'h80, b: 8'h02, p: 16'h0100};

    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b00;
    a         = '0;
    b         = '0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset%0d out_valid", s), 32'(out_valid_w[s]), 32'd0);
      check($sformatf("reset%0d p", s),         32'(p_w[s]),         32'd0);
      check($sformatf("reset%0d busy", s),      32'(busy_w[s]),      32'd0);
      check($sformatf("reset%0d in_ready", s),  32'(in_ready_w[s]),  32'd1);
    end
    rst = 2'b00;

    // out_ready with no result pending must change nothing.
    out_ready = 2'b11;
    tick();
    tick();
    out_ready = 2'b00;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("idle%0d stray out_ready {out_valid,in_ready,busy}", s),
            32'({out_valid_w[s], in_ready_w[s], busy_w[s]}), 32'b010);
    end

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 7; i++) begin
        run_mul(s, vecs[i].a, vecs[i].b, vecs[i].p, 0, 1'b0,
                $sformatf("vec%0d pipe%0d", i, s));
      end
      run_mul(s, 8'h12, 8'h34, 16'h03A8, 6, 1'b0, $sformatf("backpressure pipe%0d", s));
      run_mul(s, 8'hA5, 8'h5A, 16'h3A02, 0, 1'b1, $sformatf("scramble pipe%0d", s));
      reset_mid(s);
    end

    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_mul(1, ra, rb, 16'(ra) * 16'(rb), 0, 1'b0, $sformatf("rand%0d pipe1", i));
    end
    for (int i = 0; i < 64; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_mul(0, ra, rb, 16'(ra) * 16'(rb), 0, 1'b0, $sformatf("rand%0d pipe0", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul8_seq_ctrl.md
Name: mul8_seq_ctrl

Overview:
Sequencing controller that computes an unsigned 8x8 -> 16-bit product by time-sharing one instance of the team's existing 4x4 array multiplier (multiplier4bit) over four nibble passes. It shifts and accumulates the partial products. A valid/ready handshake on the operand side and another on the result side let it sit between a requesting datapath stage and a consumer. It owns the FSM, step counter, nibble muxes, shifter and accumulator. The 4x4 multiplier stays purely combinational.

Parameters:
- PIPE_MUL, default 0: when 1, the 4x4 product is registered before accumulation, adding 1 cycle per pass. Legal values are 0 and 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand request
- in_ready  output  1  controller can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- p  output  16  product a*b
- busy  output  1  high from accept until result handshake completes

Behaviour:
- States: IDLE, CALC, WAIT (PIPE_MUL=1 only; multiplier-register settle), DONE.
- Reset (rst=1 at a clk edge): state=IDLE, step=0, acc=0, p=0, out_valid=0, busy=0. in_ready=1 from the first cycle after reset.
- in_ready=1 only in IDLE. An accept is in_valid&in_ready at a clk edge.
- On accept: latch a, b into internal regs, clear acc to 0, set step=0, go to CALC. in_valid outside IDLE is ignored; a and b are not sampled.
- Pass order (step 0..3): 0: a[3:0]*b[3:0] <<0; 1: a[7:4]*b[3:0] <<4; 2: a[3:0]*b[7:4] <<4; 3: a[7:4]*b[7:4] <<8.
- Accumulator is 16 bits. Each 8-bit partial is zero-extended, shifted, then added. The final sum never exceeds 0xFE01, so no overflow is possible and none is flagged.
- PIPE_MUL=0: one pass per CALC cycle; acc updates at the end of that cycle; step increments.
- PIPE_MUL=1: CALC registers the partial, WAIT adds it into acc, then returns to CALC with step+1.
- After the step-3 add, go to DONE with p=acc and out_valid=1.
- Latency from accept edge to the first cycle with out_valid=1: 4 cycles for PIPE_MUL=0, 8 cycles for PIPE_MUL=1.
- DONE: out_valid and p are held stable until out_valid&out_ready. At that edge out_valid=0 and state=IDLE. p keeps the last result until the next DONE.
- Back-to-back: in_ready rises the cycle after the result handshake. This gives one bubble cycle, which is intentional. An accept and a result handshake can never fall in the same cycle.
- busy = (state != IDLE).
- rst asserted mid-operation (any state) aborts. The partial result is discarded, all outputs take their reset values, and no out_valid pulse is produced for the aborted request.
- out_ready while out_valid=0 is ignored.
- Operand changes on a/b after accept have no effect on the in-flight computation.

Test Plan:
- PIPE_MUL=0: reset, then accept a=0x12, b=0x34 -> out_valid exactly 4 cycles after accept, p=0x03A8. in_ready=0 and busy=1 throughout.
- Corner operands: 0xFF*0xFF -> p=0xFE01; 0x00*0xB7 -> p=0x0000; 0xA5*0x5A -> p=0x3A02; 0x01*0x80 -> p=0x0080.
- Backpressure: out_ready held 0 for 6 cycles after out_valid -> p and out_valid stay stable, in_valid pulses are ignored, in_ready=0. Raising out_ready completes the handshake, and in_ready=1 on the next cycle.
- Reset mid-op: accept 0xFF*0xFF, assert rst on the 2nd CALC cycle -> the next cycle has out_valid=0, p=0, busy=0, in_ready=1. No stale result is ever emitted. A following 0x03*0x05 returns p=0x000F.
- PIPE_MUL=1 regression: the same vectors give identical p values with 8-cycle latency. Also run 256 random back-to-back requests checked against a reference product, confirming a one-cycle bubble between the result handshake and the next accept.
- Operand stability: change a/b every cycle during CALC -> the result equals the product of the operands latched at accept.
